parity_stream_acc: RTL
======================

// Module: parity_stream_acc
// PURPOSE
//  Streaming parity generator/checker: folds XOR parity across every bit of
//  every beat in a frame of WIDTH-bit words. Emits one result per frame
//  through a registered valid/ready output. Sits between framed data sources
//  and link/integrity logic; generalises fixed 3-input XOR parity to any
//  width, any frame length, even/odd sense and a check mode.
// PARAMETERS
//  WIDTH       8  data bits per beat (>=1)
//  ODD_PARITY  0  0 = even parity, 1 = odd parity
//  CNT_W       8  width of beat counter; saturates at 2**CNT_W-1
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      input beat valid
//  in_ready   out  1      block can accept a beat
//  in_data    in   WIDTH  beat data
//  in_last    in   1      beat is the final beat of its frame
//  chk_en     in   1      check mode; sampled with the in_last beat
//  chk_bit    in   1      expected parity bit; sampled with the in_last beat
//  out_valid  out  1      frame result valid
//  out_ready  in   1      downstream accepts result
//  out_parity out  1      frame parity = (^all frame bits) ^ ODD_PARITY
//  out_err    out  1      chk_en ? out_parity ^ chk_bit : 0
//  out_count  out  CNT_W  beats in frame, saturating
//  out_sat    out  1      beat count saturated in this frame
// BEHAVIOUR
//  - Reset (async, any time): state=ACCUM, acc=0, cnt=0, sat=0; in_ready=1,
//    out_valid=0, out_parity=0, out_err=0, out_count=0, out_sat=0.
//    Reset mid-frame discards the partial frame; no result emitted.
//  - States: ACCUM (accepting beats), HOLD (result presented).
//  - in_ready = (state==ACCUM); purely a state decode, no comb path from
//    out_ready. Beat accepted when in_valid && in_ready.
//  - ACCUM, accepted beat, in_last=0: acc <= acc ^ (^in_data);
//    cnt <= sat-next ? max : cnt+1; sat <= sat | (cnt==max).
//  - ACCUM, accepted beat, in_last=1: out_parity <= acc^(^in_data)^ODD_PARITY;
//    out_count <= cnt+1 (saturating); out_sat <= sat | (cnt==max);
//    out_err <= chk_en & (new out_parity ^ chk_bit); out_valid <= 1;
//    acc,cnt,sat <= 0; state -> HOLD. Latency: result visible the cycle
//    after the last beat is accepted.
//  - Single-beat frame (in_last on first beat) is legal: out_count=1.
//  - HOLD: all out_* stable while out_valid && !out_ready.
//    out_valid && out_ready -> out_valid <= 0, state -> ACCUM; in_ready
//    rises the following cycle (one bubble per frame, by design).
//  - in_valid while in_ready=0: beat not taken; source must hold it.
//  - chk_en/chk_bit ignored on non-last beats; out_err=0 when chk_en=0.
//  - Saturation: with cnt at 2**CNT_W-1 further beats still fold into
//    parity; count holds at max and out_sat=1 for that frame.
//  - in_data X on unaccepted beats must not affect state.
// TESTING (WIDTH=8, ODD_PARITY=0, CNT_W=8 unless stated)
//  1 Reset: hold rst 3 cycles, release -> in_ready=1, out_valid=0, all out_*=0.
//  2 Frame 0x03,0x01,0x80(last), out_ready=1 -> next cycle out_valid=1,
//    out_parity=0, out_count=3, out_err=0; in_ready=1 two cycles later.
//  3 Single beat 0x07 last -> out_parity=1, out_count=1; ODD_PARITY=1 build
//    -> out_parity=0.
//  4 Check: 0xFF last, chk_en=1, chk_bit=1 -> out_parity=0, out_err=1;
//    repeat with chk_bit=0 -> out_err=0.
//  5 Backpressure: frame 0x01(last) with out_ready=0 for 5 cycles -> out_valid
//    and out_* stable, in_ready=0, offered next beat untaken; out_ready=1 ->
//    handshake, then next beat accepted.
//  6 CNT_W=2: 5 beats of 0x01 last on 5th -> out_count=3, out_sat=1,
//    out_parity=1; assert rst mid-frame after 2 beats -> no result, next
//    frame 0x00(last) gives out_count=1, out_parity=0, out_sat=0.

Source files
------------

// File: rtl/parity_stream_acc.sv
// Streaming XOR parity generator/checker folding every bit of every beat in a frame.
// Latency: result registered the cycle after the last beat is accepted.
// Backpressure: in_ready is low while a result is held; one bubble per frame.
module parity_stream_acc #(
  parameter int WIDTH      = 8,
  parameter int ODD_PARITY = 0,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             chk_en,
  input  logic             chk_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic             out_err,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic             ODD     = (ODD_PARITY != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic             acc;
  logic [CNT_W-1:0] cnt;
  logic             sat;

  logic             acc_nxt;
  logic             cnt_at_max;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sat_nxt;
  logic             par_fin;

  // in_ready is a pure state decode so out_ready never reaches the input side combinationally
  assign in_ready   = (state == ACCUM);

  assign acc_nxt    = acc ^ (^in_data);
  assign cnt_at_max = (cnt == CNT_MAX);
  assign cnt_nxt    = cnt_at_max ? CNT_MAX : cnt + 1'b1;
  assign sat_nxt    = sat | cnt_at_max;
  assign par_fin    = acc_nxt ^ ODD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ACCUM;
      acc        <= 1'b0;
      cnt        <= '0;
      sat        <= 1'b0;
      out_valid  <= 1'b0;
      out_parity <= 1'b0;
      out_err    <= 1'b0;
      out_count  <= '0;
      out_sat    <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          // in_data is only looked at on an accepted beat, so X on idle cycles cannot leak in
          if (in_valid) begin
            if (in_last) begin
              out_parity <= par_fin;
              out_count  <= cnt_nxt;
              out_sat    <= sat_nxt;
              out_err    <= chk_en & (par_fin ^ chk_bit);
              out_valid  <= 1'b1;
              acc        <= 1'b0;
              cnt        <= '0;
              sat        <= 1'b0;
              state      <= HOLD;
            end else begin
              acc <= acc_nxt;
              cnt <= cnt_nxt;
              sat <= sat_nxt;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
